// File: rtl/fetch_pair_unit.sv
// Dual-issue fetch stage: owns the PC, fetches 32-bit instruction pairs into a
// small circular queue and retires 0/1/2 per cycle. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_pair_unit #(
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          PC_W     = 16,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            isstall,
  input  logic            issingleinstr,
  output logic [15:0]     instr1_o,
  output logic [15:0]     instr2_o,
  output logic [1:0]      pair_valid,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     fetch_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [15:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_nxt1, wptr_nxt1;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic             discard_q, discard_d;
  logic             req_fire;
  logic             accept;
  logic [1:0]       cons;

  assign rptr_nxt1 = rptr_q + PTR_W'(1);
  assign wptr_nxt1 = wptr_q + PTR_W'(1);

  // Space check uses the pre-consume count so a push can never overflow.
  assign req_fire  = ~inflight_q & ~redirect_valid & (count_q <= CNT_W'(DEPTH - 2));
  assign imem_req  = rst_n & req_fire;
  assign imem_addr = pc_q;
  assign accept    = imem_rvalid & inflight_q & ~discard_q;

  always_comb begin
    pair_valid[0] = (count_q != '0);
    pair_valid[1] = (count_q >= CNT_W'(2));
    instr1_o      = pair_valid[0] ? mem_q[rptr_q]    : 16'h0;
    instr2_o      = pair_valid[1] ? mem_q[rptr_nxt1] : 16'h0;
  end

  always_comb begin
    if (isstall)            cons = 2'd0;
    else if (issingleinstr) cons = 2'd1;
    else                    cons = 2'd2;
    if (CNT_W'(cons) > count_q) cons = count_q[1:0];
  end

  always_comb begin
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
      pc_d    = redirect_pc;
      // A response landing in the redirect cycle retires the fetch outright.
      if (inflight_q) begin
        if (imem_rvalid) begin
          inflight_d = 1'b0;
          discard_d  = 1'b0;
        end else begin
          discard_d  = 1'b1;
        end
      end
    end else begin
      if (req_fire) begin
        pc_d       = pc_q + PC_W'(2);
        inflight_d = 1'b1;
      end
      if (imem_rvalid && inflight_q) begin
        inflight_d = 1'b0;
        discard_d  = 1'b0;
      end
      if (accept) wptr_d = wptr_q + PTR_W'(2);
      rptr_d  = rptr_q + PTR_W'(cons);
      count_d = count_q + (accept ? CNT_W'(2) : CNT_W'(0)) - CNT_W'(cons);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      discard_q  <= 1'b0;
    end else begin
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !redirect_valid) begin
      mem_q[wptr_q]    <= imem_rdata[15:0];
      mem_q[wptr_nxt1] <= imem_rdata[31:16];
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_q, fetch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      fetch_q <= '0;
    end else begin
      if (isstall && (pair_valid != 2'b00)) stall_q <= stall_q + 32'd1;
      if (accept && !redirect_valid)        fetch_q <= fetch_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign fetch_cnt = fetch_q;
`else
  assign stall_cnt = '0;
  assign fetch_cnt = '0;
`endif

endmodule

// File: doc/fetch_pair_unit.md
# fetch_pair_unit

Dual-issue instruction fetch stage directly upstream of the relayer. It owns the program counter and fetches two 16-bit instructions per memory access into a small instruction queue. Each cycle it presents the two oldest instructions as a pair to the relayer, then retires 0, 1 or 2 of them according to the relayer's `isstall` / `issingleinstr` feedback. Branch redirects flush the queue and any in-flight fetch.

## Interface
- `DEPTH`, 4, instruction queue entries (16-bit each); power of two, ≥4.
- `PC_W`, 16, program counter width; the PC counts instructions, not bytes.
- `RESET_PC`, 0, PC value after reset.

- `clk`  in  1  clock. Everything is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  one-cycle fetch request pulse.
- `imem_addr`  out  PC_W  address of the first instruction of the pair. Valid while `imem_req` is high.
- `imem_rvalid`  in  1  response strobe; any latency ≥1 cycle.
- `imem_rdata`  in  32  `[15:0]` is the instruction at addr; `[31:16]` is the instruction at addr+1.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  PC_W  new fetch PC.
- `isstall`  in  1  relayer accepted nothing this cycle.
- `issingleinstr`  in  1  relayer accepted only `instr1_o`.
- `instr1_o`  out  16  oldest queued instruction, or 16'h0 (nop) if none.
- `instr2_o`  out  16  second-oldest instruction, or nop if fewer than 2 are queued.
- `pair_valid`  out  2  bit0 = `instr1_o` valid, bit1 = `instr2_o` valid.
- `stall_cnt`  out  32  performance counter (see Configuration).
- `fetch_cnt`  out  32  performance counter (see Configuration).

## Operation
- **Queue.** Circular buffer with read and write pointers mod DEPTH and an occupancy count in 0..DEPTH.
- **Outputs.** `instr1_o`, `instr2_o` and `pair_valid` are decoded combinationally from registered queue state only. They never depend on the same-cycle `imem_rdata`.
- **Consume count** each cycle:
  - `isstall` = 1 → consume 0. `isstall` has priority over `issingleinstr`.
  - else `issingleinstr` = 1 → consume 1.
  - else → consume 2.
  - The result is then capped at the valid count. Nop padding is never consumed.
- **In-flight tracking.** A 1-bit `inflight` flag; at most one request is outstanding.
- **Request rule.** Assert `imem_req` when all hold:
  - `!inflight`
  - `!redirect_valid`
  - `DEPTH − count ≥ 2`, where count is the pre-consume value (a conservative check).
- **On request.** `imem_addr` = PC. PC ← PC + 2 (mod 2^PC_W). `inflight` ← 1.
- **Response.** `imem_rvalid` while `inflight` = 1 and `discard` = 0:
  - pushes `rdata[15:0]` and then `rdata[31:16]`;
  - clears `inflight`.
- **Stray response.** `imem_rvalid` while `inflight` = 0 is ignored.
- **Redirect.** Takes priority over push and consume in the same cycle:
  - count ← 0, pointers ← 0, PC ← `redirect_pc`;
  - if a fetch is in flight, `discard` ← 1.
- **Discarded response.** `imem_rvalid` while `discard` = 1 drops the data and clears both `discard` and `inflight`. No new request is issued until `inflight` = 0.
- **Same-cycle push and consume** are both applied: count' = count + 2 − consumed. This never overflows, because of the request rule.

## Timing
- **Reset values.** PC = RESET_PC, count = 0, `inflight` = 0, `discard` = 0, `imem_req` = 0, `instr1_o` = `instr2_o` = 16'h0, `pair_valid` = 0, counters = 0.
- **Reset mid-fetch.** The pending response is lost; its later `rvalid` is ignored by the `inflight` = 0 rule.
- **First request.** Issued in the first cycle after reset release.
- **Best-case visibility.** `rvalid` in cycle N → instructions appear on `instr1_o` / `instr2_o` in cycle N+1.
- **Redirect.** Asserted in cycle N → queue is empty in N+1. The new request issues in N+1 if nothing is in flight, otherwise one cycle after the discarded response returns.
- **Throughput.** Two instructions per (memory latency + 1) cycles while the queue has space.

## Configuration
- **Macro:** `FETCH_PERF_CNT_EN`.
- **Defined:**
  - `stall_cnt` increments (wrapping at 2^32) every cycle with `isstall` = 1 and `pair_valid` ≠ 0.
  - `fetch_cnt` increments on every accepted, non-discarded response.
- **Undefined:** the counter registers are not built, and `stall_cnt` and `fetch_cnt` are tied to 32'h0. Port list is unchanged.

## Test plan
- **Reset:** release with RESET_PC = 0 and 1-cycle memory latency returning 0x2101_1203 at address 0 → `imem_req` with addr 0 in cycle 1; in cycle 3 `instr1_o` = 16'h1203, `instr2_o` = 16'h2101, `pair_valid` = 2'b11.
- **Single-issue:** queue holds A, B, C, D; `issingleinstr` = 1 for one cycle → next cycle `instr1_o` = B, `instr2_o` = C, count = 3.
- **Stall:** `isstall` held 5 cycles with the queue full → no `imem_req`, outputs constant. With the macro defined, `stall_cnt` = 5.
- **Redirect over in-flight fetch:** `redirect_valid` with `redirect_pc` = 16'h0040 while a fetch is outstanding → the stale response is dropped, `pair_valid` = 0, and the next `imem_addr` = 16'h0040.
- **Simultaneous push and consume:** count = 2, response arrives and 2 instructions are consumed in the same cycle → count = 2, and the new pair is shown next cycle.
- **PC wrap:** redirect to 16'hFFFE → the following request is at 16'h0000.
